sm_accumulator: RTL
===================

SM_ACCUMULATOR -- requirements
Module: sm_accumulator

Interface
REQ-001 The block SHALL have parameter NBIT, default 10, meaning the width of the input sample and of the output result.
REQ-002 The block SHALL have parameter COUNT, default 4, meaning the number of samples summed per block; legal range is 2..256.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit, reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port clear_i, input, 1 bit, a synchronous abort of the current block.
REQ-006 The block SHALL have port valid_i, input, 1 bit, meaning data_i holds a sample.
REQ-007 The block SHALL have port data_i, input, NBIT bits, a two's-complement sample, i.e. the adder/subtractor result_o.
REQ-008 The block SHALL have port ready_o, output, 1 bit, meaning a sample is accepted this cycle if valid_i=1.
REQ-009 The block SHALL have port valid_o, output, 1 bit, meaning data_o and sat_o hold a finished block result.
REQ-010 The block SHALL have port ready_i, input, 1 bit, meaning the consumer takes the result this cycle.
REQ-011 The block SHALL have port data_o, output, NBIT bits, the block sum in sign-magnitude: bit NBIT-1 is the sign and the low bits are the magnitude.
REQ-012 The block SHALL have port sat_o, output, 1 bit, meaning the magnitude of data_o was clipped.

Function
REQ-013 The block SHALL keep the accumulator ACC_W = NBIT + $clog2(COUNT) bits wide and two's complement, so the internal sum never wraps.
REQ-014 The FSM SHALL have two states: ACCUM and OUT.
REQ-015 In ACCUM, ready_o SHALL be 1 and valid_o SHALL be 0.
REQ-016 In OUT, ready_o SHALL be 0 and valid_o SHALL be 1.
REQ-017 A sample is accepted when valid_i=1 and ready_o=1; the block SHALL add data_i, sign-extended to ACC_W, to the accumulator and increment the sample counter.
REQ-018 On accepting sample number COUNT, the block SHALL register the converted result of (acc + data_i) into data_o and sat_o, clear acc and the counter, and enter OUT on the next edge; latency is 1 cycle from the last accept to valid_o=1.
REQ-019 The conversion SHALL be: if the sum is >= 0, magnitude = sum and sign = 0; if the sum is < 0, magnitude = -sum and sign = 1.
REQ-020 If the magnitude exceeds 2^(NBIT-1)-1, the block SHALL clip the magnitude to 2^(NBIT-1)-1, keep the sign, and set sat_o=1; otherwise sat_o=0.
REQ-021 A zero sum SHALL give data_o = 0; negative zero SHALL never be produced.
REQ-022 In OUT, data_o and sat_o SHALL stay stable until the handshake; valid_i is ignored and no sample is lost or accumulated.
REQ-023 In OUT with ready_i=1, the block SHALL return to ACCUM on the next edge; the first sample of the next block can then be accepted one cycle later.
REQ-024 clear_i=1 SHALL override everything except reset: acc and counter are zeroed, the FSM goes to ACCUM, valid_o drops next cycle, and a sample offered in the same cycle is discarded.
REQ-025 Samples arriving with gaps (valid_i low) SHALL NOT change acc or the counter.

Reset
REQ-026 When rst_ni=0, the block SHALL immediately, without waiting for a clock, force: FSM=ACCUM, acc=0, counter=0, data_o=0, sat_o=0, valid_o=0.
REQ-027 ready_o SHALL be 1 from the first edge after reset release.
REQ-028 Reset asserted in OUT SHALL discard the pending result with no handshake.

Verification (NBIT=10, COUNT=4)
REQ-029 The bench SHALL cover: samples 5, 7, 10'h3FD (-3), 1 -> one cycle after the 4th accept, valid_o=1, data_o=10'h00A, sat_o=0.
REQ-030 The bench SHALL cover: four samples of 10'h39C (-100) -> data_o=10'h390 (-400 in sign-magnitude), sat_o=0.
REQ-031 The bench SHALL cover: four samples of 10'h0C8 (200) -> data_o=10'h1FF, sat_o=1; then four samples of 10'h300 (-256) -> data_o=10'h3FF, sat_o=1.
REQ-032 The bench SHALL cover: result pending with ready_i=0 for 3 cycles while valid_i=1 -> data_o stable, ready_o=0, nothing accumulated; ready_i=1 -> ACCUM next cycle.
REQ-033 The bench SHALL cover: 2 samples of 50, then clear_i pulse, then four samples of 1 -> data_o=10'h004.
REQ-034 The bench SHALL cover: rst_ni driven low mid-cycle while in OUT -> valid_o, data_o and sat_o go to 0 before the next clock edge.

Source files
------------

// File: rtl/sm_accumulator_if.sv
// ---------------------------------------------------------------------------
// sm_accumulator_if
//
// Purpose:
//   Bundles the sample-in and result-out handshakes of sm_accumulator.
//   Signal names are written from the accumulator's point of view.
//
// Signals:
//   valid_i  producer -> accumulator : data_i holds a sample
//   data_i   producer -> accumulator : two's-complement sample, NBIT bits
//   ready_o  accumulator -> producer : a sample is taken this cycle if valid_i
//   valid_o  accumulator -> consumer : data_o / sat_o hold a finished result
//   ready_i  consumer -> accumulator : consumer takes the result this cycle
//   data_o   accumulator -> consumer : sign-magnitude block sum, NBIT bits
//   sat_o    accumulator -> consumer : the magnitude of data_o was clipped
//
// Modports:
//   master : the environment (drives samples and result-ready)
//   slave  : the accumulator itself
// ---------------------------------------------------------------------------
interface sm_accumulator_if #(
    parameter int NBIT = 10
);

    logic            valid_i;
    logic [NBIT-1:0] data_i;
    logic            ready_o;
    logic            valid_o;
    logic            ready_i;
    logic [NBIT-1:0] data_o;
    logic            sat_o;

    modport master (
        output valid_i,
        output data_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  data_o,
        input  sat_o
    );

    modport slave (
        input  valid_i,
        input  data_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output data_o,
        output sat_o
    );

endinterface

// File: rtl/sm_accumulator.sv
// ---------------------------------------------------------------------------
// sm_accumulator
//
// Purpose:
//   Sums COUNT consecutive two's-complement samples into a wide accumulator
//   that can never wrap, then presents the block sum in sign-magnitude form,
//   clipping the magnitude to the largest value NBIT-1 bits can hold.
//   The result is held until the consumer handshakes it away.
//
// Parameters:
//   NBIT   width of each input sample and of the output result
//   COUNT  number of samples summed per block (2..256)
//
// Ports:
//   clk_i    single clock, rising edge
//   rst_ni   asynchronous active-low reset
//   clear_i  synchronous abort of the block in progress (or of a pending result)
//   bus      sm_accumulator_if.slave carrying the sample and result handshakes
// ---------------------------------------------------------------------------
module sm_accumulator #(
    parameter int NBIT  = 10,
    parameter int COUNT = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    sm_accumulator_if.slave bus
);

    // Accumulator wide enough that COUNT full-scale samples cannot overflow.
    localparam int ACC_W = NBIT + $clog2(COUNT);
    // Counter holds 0..COUNT-1; the COUNT-th accept is detected, not stored.
    localparam int CNT_W = $clog2(COUNT);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);
    localparam logic [ACC_W-1:0] MAX_MAG  = {{(ACC_W - NBIT + 1){1'b0}}, {(NBIT - 1){1'b1}}};

    typedef enum logic {
        ACCUM,
        OUT
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic [NBIT-1:0]    r_dataOut;
    logic               r_sat;

    logic               w_accept;
    logic               w_lastSample;
    logic               w_readyOut;
    logic               w_validOut;
    logic [ACC_W-1:0]   w_sampleExt;
    logic [ACC_W-1:0]   w_sum;
    logic               w_neg;
    logic [ACC_W-1:0]   w_mag;
    logic               w_satNow;
    logic [NBIT-2:0]    w_magOut;

    // Sign-extend the incoming sample and form the running sum including it.
    // This sum is what gets converted when the last sample of a block lands,
    // so the result is ready on the very next edge.
    assign w_sampleExt = {{(ACC_W - NBIT){bus.data_i[NBIT-1]}}, bus.data_i};
    assign w_sum       = r_acc + w_sampleExt;

    // Two's-complement to sign-magnitude with clipping. A zero sum has a
    // clear sign bit, so negative zero cannot appear. Negating the most
    // negative accumulator value gives the same bit pattern, which read as
    // unsigned is exactly its magnitude, so the compare below still works.
    always_comb begin
        w_neg    = w_sum[ACC_W-1];
        w_mag    = w_neg ? -w_sum : w_sum;
        w_satNow = (w_mag > MAX_MAG);
        w_magOut = w_satNow ? {(NBIT - 1){1'b1}} : w_mag[NBIT-2:0];
    end

    // State register. Reset is asynchronous so the pending result and
    // valid_o vanish immediately, without waiting for a clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs. ACCUM always accepts samples;
    // OUT only offers the result. clear_i wins over every other input and
    // always lands the machine back in ACCUM.
    always_comb begin
        w_nextState  = r_state;
        w_readyOut   = 1'b0;
        w_validOut   = 1'b0;
        w_accept     = 1'b0;
        w_lastSample = (r_count == LAST_IDX);

        unique case (r_state)
            ACCUM: begin
                w_readyOut = 1'b1;
                w_accept   = bus.valid_i && !clear_i;
                if (w_accept && w_lastSample) begin
                    w_nextState = OUT;
                end
            end
            OUT: begin
                w_validOut = 1'b1;
                if (clear_i || bus.ready_i) begin
                    w_nextState = ACCUM;
                end
            end
            default: begin
                w_nextState = ACCUM;
            end
        endcase
    end

    // Datapath: accumulator, sample counter and the held result.
    // On the last sample the converted sum is captured and the accumulator
    // restarts from zero, so the next block begins clean. The result
    // registers only change on that capture, which keeps data_o and sat_o
    // stable for as long as the consumer stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc     <= '0;
            r_count   <= '0;
            r_dataOut <= '0;
            r_sat     <= 1'b0;
        end else if (clear_i) begin
            r_acc     <= '0;
            r_count   <= '0;
        end else if (w_accept) begin
            if (w_lastSample) begin
                r_acc     <= '0;
                r_count   <= '0;
                r_dataOut <= {w_neg, w_magOut};
                r_sat     <= w_satNow;
            end else begin
                r_acc     <= w_sum;
                r_count   <= r_count + CNT_W'(1);
            end
        end
    end

    assign bus.ready_o = w_readyOut;
    assign bus.valid_o = w_validOut;
    assign bus.data_o  = r_dataOut;
    assign bus.sat_o   = r_sat;

    // The two directions of the handshake never overlap.
    a_readyValidExclusive : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(bus.ready_o && bus.valid_o)
    );

    // A stalled result must not change underneath the consumer.
    a_resultStable : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (bus.valid_o && !bus.ready_i && !clear_i) |=> ($stable(bus.data_o) && $stable(bus.sat_o))
    );

endmodule
